stopwatch_sequencer: RTL and testbench

STOPWATCH_SEQUENCER -- requirements
Module: stopwatch_sequencer

---
 rtl/stopwatch_pkg.sv | 52 +++++
 rtl/stopwatch_sequencer_if.sv | 26 ++
 rtl/stopwatch_sequencer_bcd_digit_counter.sv | 37 +++
 rtl/stopwatch_sequencer.sv | 123 ++++++++++++
 tb/tb_stopwatch_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : State encodings, digit moduli and BCD field layout for the stopwatch.
// Revision : 1.0
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP_RUN = 2'd3
  } swState_t;

  localparam int c_numDigits  = 8;
  localparam int c_digitWidth = 4;
  localparam int c_decModulus = 10;
  localparam int c_sexModulus = 6;

  localparam int c_hundUnitsLsb = 0;
  localparam int c_hundTensLsb  = 4;
  localparam int c_secUnitsLsb  = 8;
  localparam int c_secTensLsb   = 12;
  localparam int c_minUnitsLsb  = 16;
  localparam int c_minTensLsb   = 20;
  localparam int c_hrUnitsLsb   = 24;
  localparam int c_hrTensLsb    = 28;

  // Digit index 0 is hundredths-units, 7 is hours-tens.
  function automatic int digitModulus(input int idx);
    case (idx)
      3, 5:    return c_sexModulus;
      default: return c_decModulus;
    endcase
  endfunction

  function automatic int digitLsb(input int idx);
    case (idx)
      0:       return c_hundUnitsLsb;
      1:       return c_hundTensLsb;
      2:       return c_secUnitsLsb;
      3:       return c_secTensLsb;
      4:       return c_minUnitsLsb;
      5:       return c_minTensLsb;
      6:       return c_hrUnitsLsb;
      default: return c_hrTensLsb;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_sequencer_if
// Brief    : Control pulses and display/status outputs of the stopwatch.
// Revision : 1.0
// ============================================================================
interface stopwatch_sequencer_if;
  logic        startStopIn;
  logic        lapIn;
  logic        clearIn;
  logic [31:0] digitsOut;
  logic [1:0]  stateOut;
  logic        tickOut;
  logic        wrapOut;

  modport master (
    output startStopIn, lapIn, clearIn,
    input  digitsOut, stateOut, tickOut, wrapOut
  );

  modport slave (
    input  startStopIn, lapIn, clearIn,
    output digitsOut, stateOut, tickOut, wrapOut
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_sequencer_bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_counter
// Brief    : One BCD digit counting 0..MODULUS-1 with clear and ripple carry.
// Revision : 1.0
// ============================================================================
module bcd_digit_counter #(
  parameter int MODULUS = 10
) (
  input  wire logic       clk,
  input  wire logic       clear,
  input  wire logic       carryIn,
  output logic      [3:0] digit,
  output logic            carryOut
);

  logic [3:0] r_digit;
  logic [3:0] w_digitNext;

  assign carryOut = carryIn && (r_digit == 4'(MODULUS - 1));
  assign digit    = r_digit;

  always_comb begin
    w_digitNext = r_digit;
    if (clear) begin
      w_digitNext = '0;
    end else if (carryIn) begin
      w_digitNext = (r_digit == 4'(MODULUS - 1)) ? 4'd0 : r_digit + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_digit <= w_digitNext;
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_sequencer
// Brief    : HH:MM:SS.hh stopwatch with run/pause, lap freeze and clear.
// Revision : 1.0
// ============================================================================
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100
) (
  input wire logic              clkIn,
  input wire logic              rstIn,
  stopwatch_sequencer_if.slave  bus
);

  localparam int c_div      = CLK_HZ / TICK_HZ;
  localparam int c_preWidth = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_preWidth-1:0] c_preMax = c_preWidth'(c_div - 1);

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || c_div < 2) begin : g_paramCheck
      $error("stopwatch_sequencer: CLK_HZ must be a multiple of TICK_HZ with ratio >= 2");
    end
  endgenerate

  swState_t                r_state;
  swState_t                w_stateNext;
  logic [c_preWidth-1:0]   r_prescaler;
  logic [c_preWidth-1:0]   w_preNext;
  logic [31:0]             r_snapshot;
  logic                    r_tick;
  logic                    r_wrap;
  logic                    w_clearTaken;
  logic                    w_snapLoad;
  logic                    w_advance;
  logic                    w_tickEn;
  logic                    w_digitClear;
  logic [31:0]             w_count;
  logic [c_numDigits:0]    w_carry;

  assign w_clearTaken = bus.clearIn;
  assign w_digitClear = !rstIn || w_clearTaken;

  always_comb begin
    w_stateNext = r_state;
    w_snapLoad  = 1'b0;
    if (bus.clearIn) begin
      w_stateNext = IDLE;
    end else if (bus.startStopIn) begin
      case (r_state)
        IDLE, PAUSED:     w_stateNext = RUNNING;
        RUNNING, LAP_RUN: w_stateNext = PAUSED;
        default:          w_stateNext = IDLE;
      endcase
    end else if (bus.lapIn) begin
      if (r_state == RUNNING) begin
        w_stateNext = LAP_RUN;
        w_snapLoad  = 1'b1;
      end else if (r_state == LAP_RUN) begin
        w_stateNext = RUNNING;
      end
    end
  end

  // The phase advances on every edge that lands in a live state, so the start
  // cycle itself counts as the first prescaler phase.
  assign w_advance = !w_clearTaken && (w_stateNext == RUNNING || w_stateNext == LAP_RUN);
  assign w_tickEn  = w_advance && (r_prescaler == c_preMax);

  always_comb begin
    w_preNext = r_prescaler;
    if (w_clearTaken || w_stateNext == IDLE) begin
      w_preNext = '0;
    end else if (w_advance) begin
      w_preNext = (r_prescaler == c_preMax) ? '0 : r_prescaler + c_preWidth'(1);
    end
  end

  assign w_carry[0] = w_tickEn;

  generate
    for (genvar i = 0; i < c_numDigits; i++) begin : g_digit
      bcd_digit_counter #(
        .MODULUS (digitModulus(i))
      ) u_digit (
        .clk      (clkIn),
        .clear    (w_digitClear),
        .carryIn  (w_carry[i]),
        .digit    (w_count[digitLsb(i) +: c_digitWidth]),
        .carryOut (w_carry[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      r_state     <= IDLE;
      r_prescaler <= '0;
      r_snapshot  <= '0;
      r_tick      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_prescaler <= w_preNext;
      r_tick      <= w_tickEn;
      r_wrap      <= w_carry[c_numDigits];
      if (w_clearTaken) begin
        r_snapshot <= '0;
      end else if (w_snapLoad) begin
        r_snapshot <= w_count;
      end
    end
  end

  assign bus.digitsOut = (r_state == LAP_RUN) ? r_snapshot : w_count;
  assign bus.stateOut  = r_state;
  assign bus.tickOut   = r_tick;
  assign bus.wrapOut   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_sequencer
// Brief    : Directed bench with a time-arithmetic reference model of the stopwatch.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_sequencer;

  localparam int c_clkHz  = 20;
  localparam int c_tickHz = 2;
  localparam int c_div    = c_clkHz / c_tickHz;
  localparam int c_maxCnt = 100 * 60 * 60 * 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   modelOn  = 1'b0;
  logic [31:0] preVal = '0;

  // Reference model: total hundredths elapsed plus prescaler phase.
  int mState = 0;
  int mCount = 0;
  int mSnap  = 0;
  int mPhase = 0;
  bit mTick  = 1'b0;
  bit mWrap  = 1'b0;

  stopwatch_sequencer_if sw ();

  stopwatch_sequencer #(
    .CLK_HZ  (c_clkHz),
    .TICK_HZ (c_tickHz)
  ) dut (
    .clkIn (clk),
    .rstIn (rst),
    .bus   (sw.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] toBcd(input int c);
    int hu, s, m, h;
    hu = c % 100;
    s  = (c / 100) % 60;
    m  = (c / 6000) % 60;
    h  = c / 360000;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(hu / 10), 4'(hu % 10)};
  endfunction

  function automatic int fromBcd(input logic [31:0] b);
    int hu, s, m, h;
    hu = int'(b[7:4]) * 10 + int'(b[3:0]);
    s  = int'(b[15:12]) * 10 + int'(b[11:8]);
    m  = int'(b[23:20]) * 10 + int'(b[19:16]);
    h  = int'(b[31:28]) * 10 + int'(b[27:24]);
    return ((h * 60 + m) * 60 + s) * 100 + hu;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int nextS;
    bit live;
    if (!rst) begin
      mState = 0; mCount = 0; mSnap = 0; mPhase = 0; mTick = 0; mWrap = 0;
    end else begin
      nextS = mState;
      mTick = 0;
      mWrap = 0;
      if (sw.clearIn) nextS = 0;
      else if (sw.startStopIn) nextS = (mState == 1 || mState == 3) ? 2 : 1;
      else if (sw.lapIn && mState == 1) begin nextS = 3; mSnap = mCount; end
      else if (sw.lapIn && mState == 3) nextS = 1;
      live = !sw.clearIn && (nextS == 1 || nextS == 3);
      if (sw.clearIn) begin
        mCount = 0; mSnap = 0; mPhase = 0;
      end else if (nextS == 0) begin
        mPhase = 0;
      end else if (live) begin
        if (mPhase == c_div - 1) begin
          mPhase = 0;
          mTick  = 1;
          mCount = (mCount + 1) % c_maxCnt;
          mWrap  = (mCount == 0);
        end else begin
          mPhase++;
        end
      end
      mState = nextS;
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      check("cmp digits", sw.digitsOut, (mState == 3) ? toBcd(mSnap) : toBcd(mCount));
      check("cmp state",  32'(sw.stateOut), 32'(mState));
      check("cmp tick",   32'(sw.tickOut),  32'(mTick));
      check("cmp wrap",   32'(sw.wrapOut),  32'(mWrap));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input bit s, input bit l, input bit c);
    sw.startStopIn = s;
    sw.lapIn       = l;
    sw.clearIn     = c;
    cyc(1);
    sw.startStopIn = 0;
    sw.lapIn       = 0;
    sw.clearIn     = 0;
  endtask

  // Holds the digit registers across one edge so they adopt the new value.
  task automatic preload(input logic [31:0] v);
    preVal = v;
    mCount = fromBcd(v);
    force dut.g_digit[0].u_digit.r_digit = preVal[3:0];
    force dut.g_digit[1].u_digit.r_digit = preVal[7:4];
    force dut.g_digit[2].u_digit.r_digit = preVal[11:8];
    force dut.g_digit[3].u_digit.r_digit = preVal[15:12];
    force dut.g_digit[4].u_digit.r_digit = preVal[19:16];
    force dut.g_digit[5].u_digit.r_digit = preVal[23:20];
    force dut.g_digit[6].u_digit.r_digit = preVal[27:24];
    force dut.g_digit[7].u_digit.r_digit = preVal[31:28];
    cyc(1);
    release dut.g_digit[0].u_digit.r_digit;
    release dut.g_digit[1].u_digit.r_digit;
    release dut.g_digit[2].u_digit.r_digit;
    release dut.g_digit[3].u_digit.r_digit;
    release dut.g_digit[4].u_digit.r_digit;
    release dut.g_digit[5].u_digit.r_digit;
    release dut.g_digit[6].u_digit.r_digit;
    release dut.g_digit[7].u_digit.r_digit;
  endtask

  initial begin
    sw.startStopIn = 0;
    sw.lapIn       = 0;
    sw.clearIn     = 0;
    cyc(3);
    modelOn = 1;
    check("reset digits", sw.digitsOut, 32'h0);
    check("reset state",  32'(sw.stateOut), 32'd0);
    check("reset tick",   32'(sw.tickOut), 32'd0);
    check("reset wrap",   32'(sw.wrapOut), 32'd0);
    rst = 1;

    // Start from IDLE: first increment visible 10 cycles after the pulse cycle.
    pulse(1, 0, 0);
    cyc(8);
    check("start c9 digits", sw.digitsOut, 32'h0);
    check("start c9 tick",   32'(sw.tickOut), 32'd0);
    cyc(1);
    check("start c10 digits", sw.digitsOut, 32'h1);
    check("start c10 tick",   32'(sw.tickOut), 32'd1);
    check("start c10 state",  32'(sw.stateOut), 32'd1);
    cyc(1);
    check("start c11 tick", 32'(sw.tickOut), 32'd0);
    cyc(9);
    check("start c20 digits", sw.digitsOut, 32'h2);
    check("start c20 tick",   32'(sw.tickOut), 32'd1);

    // Pause 4 cycles past a tick, resume, next increment 6 cycles later.
    cyc(4);
    pulse(1, 0, 0);
    check("pause state", 32'(sw.stateOut), 32'd2);
    cyc(50);
    check("pause hold digits", sw.digitsOut, 32'h2);
    pulse(1, 0, 0);
    cyc(4);
    check("resume r5 digits", sw.digitsOut, 32'h2);
    check("resume r5 tick",   32'(sw.tickOut), 32'd0);
    cyc(1);
    check("resume r6 digits", sw.digitsOut, 32'h3);
    check("resume r6 tick",   32'(sw.tickOut), 32'd1);

    // Lap freeze and release.
    pulse(0, 1, 0);
    check("lap state", 32'(sw.stateOut), 32'd3);
    cyc(29);
    check("lap hold digits", sw.digitsOut, 32'h3);
    pulse(0, 1, 0);
    check("lap release digits", sw.digitsOut, 32'h6);
    check("lap release state",  32'(sw.stateOut), 32'd1);

    // All three pulses on the tick cycle: clear wins, no increment.
    cyc(8);
    pulse(1, 1, 1);
    check("prio state",  32'(sw.stateOut), 32'd0);
    check("prio digits", sw.digitsOut, 32'h0);
    check("prio tick",   32'(sw.tickOut), 32'd0);

    // Seconds to minutes carry.
    preload(32'h00005999);
    check("preload idle digits", sw.digitsOut, 32'h00005999);
    pulse(1, 0, 0);
    cyc(9);
    check("carry digits", sw.digitsOut, 32'h00010000);
    check("carry tick",   32'(sw.tickOut), 32'd1);

    // Full rollover.
    preload(32'h99595999);
    cyc(8);
    check("wrap pre digits", sw.digitsOut, 32'h99595999);
    cyc(1);
    check("wrap digits", sw.digitsOut, 32'h0);
    check("wrap tick",   32'(sw.tickOut), 32'd1);
    check("wrap wrap",   32'(sw.wrapOut), 32'd1);
    check("wrap state",  32'(sw.stateOut), 32'd1);
    cyc(1);
    check("wrap after wrap", 32'(sw.wrapOut), 32'd0);
    check("wrap after tick", 32'(sw.tickOut), 32'd0);

    // Reset on a tick cycle with a start pulse that must be ignored.
    cyc(8);
    rst = 0;
    sw.startStopIn = 1;
    cyc(1);
    rst = 1;
    sw.startStopIn = 0;
    check("midreset digits", sw.digitsOut, 32'h0);
    check("midreset state",  32'(sw.stateOut), 32'd0);
    check("midreset tick",   32'(sw.tickOut), 32'd0);
    check("midreset wrap",   32'(sw.wrapOut), 32'd0);
    pulse(1, 0, 0);
    cyc(8);
    check("restart c9 digits", sw.digitsOut, 32'h0);
    cyc(1);
    check("restart c10 digits", sw.digitsOut, 32'h1);
    check("restart c10 tick",   32'(sw.tickOut), 32'd1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
